// File: rtl/i2c_pkg.sv
// Shared definitions for the PC-instruction receive path and the I2C side.
// Holds the parser FSM states, the one-hot mode codes, the error codes and
// the payload-length decode. The CHK state exists only when
// UART_FRAME_CHECKSUM_EN is defined.
package i2c_pkg;

    localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;

    // Low nibble of the mode byte selects the operation
    localparam logic [3:0] MODE_RD1 = 4'b0001;
    localparam logic [3:0] MODE_RD2 = 4'b0010;
    localparam logic [3:0] MODE_WR1 = 4'b0100;
    localparam logic [3:0] MODE_WR2 = 4'b1000;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_MODE    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MODE,
        ST_ADDR,
        ST_D_HI,
        ST_D_LO,
`ifdef UART_FRAME_CHECKSUM_EN
        ST_CHK,
`endif
        ST_ISSUE
    } state_e;

    function automatic logic is_onehot4(input logic [3:0] m);
        return (m != 4'd0) && ((m & (m - 4'd1)) == 4'd0);
    endfunction

    // Number of data bytes that follow the address byte
    function automatic logic [1:0] payload_len(input logic [3:0] m);
        case (m)
            MODE_WR2: return 2'd2;
            MODE_WR1: return 2'd1;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/rx_frame_timer.sv
// Saturating inter-byte timeout counter. Clear has priority over enable;
// expired stays high while the count sits at LIMIT.
module rx_frame_timer #(
    parameter int LIMIT = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int           W       = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear, or step up until the limit is reached
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT_W)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT_W);

endmodule

// File: rtl/uart_i2c_instr_assembler.sv
// Parses framed PC instructions (header, mode, address, 0-2 data bytes) from
// the UART receive byte stream and offers one complete instruction to the
// I2C controller over valid/ready. Bad mode, inter-byte timeout and bytes
// arriving while an instruction is pending are flagged on frame_error.
// Optional build macro UART_FRAME_CHECKSUM_EN adds a trailing XOR check byte.
module uart_i2c_instr_assembler
    import i2c_pkg::*;
#(
    parameter logic [7:0] HEADER_BYTE    = HEADER_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        i2c_ready,
    output logic        instr_valid,
    output logic [7:0]  instr_mode,
    output logic [7:0]  instr_address,
    output logic [15:0] instr_data,
    output logic        busy,
    output logic        frame_error,
    output logic [1:0]  err_code
);

    state_e      state_q, state_d;
    logic [7:0]  mode_q, mode_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        fe_q, fe_d;
    logic [1:0]  err_q, err_d;
    logic        counting;
    logic        tmr_clear;
    logic        tmr_expired;

`ifdef UART_FRAME_CHECKSUM_EN
    localparam state_e PAYLOAD_DONE = ST_CHK;
    // Unused data bytes are held at zero, so XOR of the latched fields
    // equals the XOR of every payload byte received.
    logic [7:0] chk_calc;
    assign chk_calc = mode_q ^ addr_q ^ data_q[15:8] ^ data_q[7:0];
`else
    localparam state_e PAYLOAD_DONE = ST_ISSUE;
`endif

    // Timer runs only while a frame is being collected; any byte restarts it
    assign counting  = (state_q != ST_IDLE) && (state_q != ST_ISSUE);
    assign tmr_clear = rx_valid || !counting;

    rx_frame_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (counting),
        .expired (tmr_expired)
    );

    // Frame parser: next state, latched fields and error reporting
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        data_d  = data_q;
        fe_d    = 1'b0;
        err_d   = err_q;
        if (counting && !rx_valid && tmr_expired) begin
            // A byte in the expiry cycle wins, so only abort on silence
            fe_d    = 1'b1;
            err_d   = ERR_TIMEOUT;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid && (rx_data == HEADER_BYTE)) begin
                        data_d  = '0;
                        state_d = ST_MODE;
                    end
                end
                ST_MODE: begin
                    if (rx_valid) begin
                        if (is_onehot4(rx_data[3:0])) begin
                            mode_d  = rx_data;
                            state_d = ST_ADDR;
                        end else begin
                            fe_d    = 1'b1;
                            err_d   = ERR_MODE;
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_valid) begin
                        addr_d = rx_data;
                        case (payload_len(mode_q[3:0]))
                            2'd2:    state_d = ST_D_HI;
                            2'd1:    state_d = ST_D_LO;
                            default: state_d = PAYLOAD_DONE;
                        endcase
                    end
                end
                ST_D_HI: begin
                    if (rx_valid) begin
                        data_d[15:8] = rx_data;
                        state_d      = ST_D_LO;
                    end
                end
                ST_D_LO: begin
                    if (rx_valid) begin
                        data_d[7:0] = rx_data;
                        state_d     = PAYLOAD_DONE;
                    end
                end
`ifdef UART_FRAME_CHECKSUM_EN
                ST_CHK: begin
                    if (rx_valid) begin
                        if (rx_data == chk_calc) begin
                            state_d = ST_ISSUE;
                        end else begin
                            fe_d    = 1'b1;
                            err_d   = ERR_OVERRUN;
                            state_d = ST_IDLE;
                        end
                    end
                end
`endif
                ST_ISSUE: begin
                    // Stray byte is dropped; pending instruction untouched
                    if (rx_valid) begin
                        fe_d  = 1'b1;
                        err_d = ERR_OVERRUN;
                    end
                    if (i2c_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and field registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            fe_q    <= 1'b0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            fe_q    <= fe_d;
            err_q   <= err_d;
        end
    end

    assign instr_valid   = (state_q == ST_ISSUE);
    assign instr_mode    = mode_q;
    assign instr_address = addr_q;
    assign instr_data    = data_q;
    assign busy          = (state_q != ST_IDLE);
    assign frame_error   = fe_q;
    assign err_code      = err_q;

endmodule

// File: tb/tb_uart_i2c_instr_assembler.sv
// Directed plus randomized bench for uart_i2c_instr_assembler. Expected
// instructions are built from the frame contents (mode decides payload
// length, unused data bytes read as zero); expected error codes are tracked
// as a single "last error" variable.
module tb_uart_i2c_instr_assembler;

    localparam int T = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        i2c_ready = 1'b0;
    logic        instr_valid;
    logic [7:0]  instr_mode;
    logic [7:0]  instr_address;
    logic [15:0] instr_data;
    logic        busy;
    logic        frame_error;
    logic [1:0]  err_code;

    int          errors = 0;
    int          checks = 0;
    logic [1:0]  exp_err = 2'b00;

    always #5 clk = ~clk;

    uart_i2c_instr_assembler #(
        .HEADER_BYTE    (8'hA5),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .i2c_ready     (i2c_ready),
        .instr_valid   (instr_valid),
        .instr_mode    (instr_mode),
        .instr_address (instr_address),
        .instr_data    (instr_data),
        .busy          (busy),
        .frame_error   (frame_error),
        .err_code      (err_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    function automatic int plen(input logic [7:0] m);
        if (m[3:0] == 4'b1000) return 2;
        if (m[3:0] == 4'b0100) return 1;
        return 0;
    endfunction

    // Send a well-formed frame; ed returns the data the instruction should carry
    task automatic send_frame(input logic [7:0] m, input logic [7:0] a, input logic [15:0] d,
                              input int gap, output logic [15:0] ed);
        logic [7:0] q[$];
        int n;
        n  = plen(m);
        q  = {8'hA5, m, a};
        if (n == 2) q.push_back(d[15:8]);
        if (n >= 1) q.push_back(d[7:0]);
        ed = (n == 2) ? d : (n == 1) ? {8'h00, d[7:0]} : 16'h0000;
`ifdef UART_FRAME_CHECKSUM_EN
        q.push_back(m ^ a ^ ed[15:8] ^ ed[7:0]);
`endif
        foreach (q[i]) begin
            if (i > 0) repeat (gap) tick();
            send_byte(q[i]);
            if (i < q.size() - 1) chk("mid_frame_valid", instr_valid, 0);
            chk("good_frame_no_fe", frame_error, 0);
        end
    endtask

    // Instruction must be up right after the last byte and held through a stall
    task automatic expect_issue(input logic [7:0] m, input logic [7:0] a, input logic [15:0] ed,
                                input int stall);
        chk("issue_valid", instr_valid, 1);
        chk("issue_mode", instr_mode, m);
        chk("issue_addr", instr_address, a);
        chk("issue_data", instr_data, ed);
        chk("issue_busy", busy, 1);
        chk("issue_err_hold", err_code, exp_err);
        repeat (stall) begin
            tick();
            chk("stall_valid", instr_valid, 1);
            chk("stall_data", {instr_mode, instr_address, instr_data}, {m, a, ed});
        end
        i2c_ready = 1'b1;
        tick();
        i2c_ready = 1'b0;
        chk("post_hs_valid", instr_valid, 0);
        chk("post_hs_busy", busy, 0);
        chk("post_hs_fe", frame_error, 0);
    endtask

    task automatic bad_mode(input logic [7:0] m);
        send_byte(8'hA5);
        send_byte(m);
        exp_err = 2'b01;
        chk("badmode_fe", frame_error, 1);
        chk("badmode_err", err_code, exp_err);
        chk("badmode_valid", instr_valid, 0);
        chk("badmode_busy", busy, 0);
        tick();
        chk("badmode_fe_pulse", frame_error, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(tag, {instr_valid, instr_mode, instr_address, instr_data, busy, frame_error, err_code},
            32'h0);
    endtask

    initial begin
        logic [15:0] ed;
        logic [7:0]  m, a, bm;
        logic [3:0]  lo;
        int          gap, stall;

        // Reset state
        repeat (3) tick();
        check_reset_outputs("reset_outputs");
        reset = 1'b1;
        tick();

        // Non-header byte in IDLE is ignored
        send_byte(8'h11);
        chk("idle_junk_busy", busy, 0);
        chk("idle_junk_fe", frame_error, 0);

        // rd1, accepted immediately
        send_frame(8'h01, 8'h48, 16'hFFFF, 0, ed);
        expect_issue(8'h01, 8'h48, ed, 0);

        // wr2 with a 10-cycle I2C stall
        send_frame(8'h08, 8'h20, 16'h1234, 0, ed);
        expect_issue(8'h08, 8'h20, ed, 10);

        // wr1: high data byte reads zero
        send_frame(8'h04, 8'h03, 16'hAB7F, 0, ed);
        expect_issue(8'h04, 8'h03, ed, 1);

        // Mode with two bits set
        bad_mode(8'h03);

        // Header value inside the frame is data; upper mode nibble passes through
        send_frame(8'hA8, 8'hA5, 16'hA5A5, 1, ed);
        expect_issue(8'hA8, 8'hA5, ed, 2);

        // Silence for one cycle past the limit aborts the frame
        send_byte(8'hA5);
        send_byte(8'h02);
        repeat (T) tick();
        chk("pre_timeout_fe", frame_error, 0);
        chk("pre_timeout_busy", busy, 1);
        tick();
        exp_err = 2'b10;
        chk("timeout_fe", frame_error, 1);
        chk("timeout_err", err_code, exp_err);
        chk("timeout_busy", busy, 0);
        chk("timeout_valid", instr_valid, 0);
        tick();
        chk("timeout_fe_pulse", frame_error, 0);

        // Bytes arriving exactly at the limit are accepted
        send_frame(8'h02, 8'h5A, 16'h0000, T, ed);
        expect_issue(8'h02, 8'h5A, ed, 1);
        send_frame(8'h48, 8'h77, 16'hC3E1, T, ed);
        expect_issue(8'h48, 8'h77, ed, 0);

        // Stray byte while an instruction is pending
        send_frame(8'h38, 8'h10, 16'hBEEF, 0, ed);
        send_byte(8'h55);
        exp_err = 2'b11;
        chk("overrun_fe", frame_error, 1);
        chk("overrun_err", err_code, exp_err);
        chk("overrun_valid", instr_valid, 1);
        chk("overrun_fields", {instr_mode, instr_address, instr_data}, {8'h38, 8'h10, 16'hBEEF});
        expect_issue(8'h38, 8'h10, ed, 2);

        // Reset in the middle of a frame
        send_byte(8'hA5);
        send_byte(8'h08);
        send_byte(8'h20);
        reset = 1'b0;
        tick();
        check_reset_outputs("reset_mid_frame");
        reset = 1'b1;
        exp_err = 2'b00;
        tick();
        chk("after_reset_fe", frame_error, 0);

        // Reset while an instruction is pending
        send_frame(8'h01, 8'h66, 16'h0000, 0, ed);
        reset = 1'b0;
        tick();
        check_reset_outputs("reset_mid_issue");
        reset = 1'b1;
        tick();

`ifdef UART_FRAME_CHECKSUM_EN
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h48);
        send_byte(8'h49);
        expect_issue(8'h01, 8'h48, 16'h0000, 0);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h48);
        send_byte(8'h00);
        exp_err = 2'b11;
        chk("chk_bad_fe", frame_error, 1);
        chk("chk_bad_err", err_code, exp_err);
        chk("chk_bad_valid", instr_valid, 0);
        tick();
`endif

        // Randomized frames, with occasional bad modes and limit-length gaps
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                bm = 8'($urandom);
                while (bm[3:0] == 4'h1 || bm[3:0] == 4'h2 || bm[3:0] == 4'h4 || bm[3:0] == 4'h8)
                    bm = 8'($urandom);
                bad_mode(bm);
            end else begin
                lo    = 4'b0001 << $urandom_range(0, 3);
                m     = {4'($urandom), lo};
                a     = 8'($urandom);
                gap   = ($urandom_range(0, 7) == 0) ? T : $urandom_range(0, 3);
                stall = $urandom_range(0, 4);
                send_frame(m, a, 16'($urandom), gap, ed);
                expect_issue(m, a, ed, stall);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_i2c_instr_assembler.md
Name: uart_i2c_instr_assembler

Overview:
Receive-side counterpart of the I2C-to-PC result path. Consumes the byte stream from the UART receiver (PC to FPGA), parses framed PC instructions (header, mode, address, 0-2 data bytes), and presents one complete instruction to the I2C controller over a valid/ready handshake. Malformed, stalled or overrun frames are dropped and flagged, and are never issued.

Parameters:
HEADER_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 50000, max idle clk cycles between bytes inside a frame before abort (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
rx_data  in  8  byte from UART receiver
rx_valid  in  1  1-cycle strobe, rx_data valid
i2c_ready  in  1  I2C controller accepts instruction this cycle
instr_valid  out  1  instruction presented
instr_mode  out  8  mode byte; [3:0] one-hot: 0001 rd1, 0010 rd2, 0100 wr1, 1000 wr2; [7:4] passed through
instr_address  out  8  register address
instr_data  out  16  write data (zero for reads)
busy  out  1  frame in progress or instruction pending
frame_error  out  1  1-cycle pulse on dropped frame
err_code  out  2  cause of last error: 01 bad mode, 10 timeout, 11 overrun/checksum; holds until next error

Behaviour:
- Reset: all outputs 0, FSM to IDLE, timeout counter cleared. Reset mid-frame or mid-issue discards the instruction silently (no frame_error).
- States: IDLE -> MODE -> ADDR -> [D_HI] -> D_LO -> [CHK] -> ISSUE -> IDLE. Transitions occur only on a rx_valid byte, except from ISSUE.
- IDLE: ignore bytes other than HEADER_BYTE. HEADER_BYTE -> MODE.
- MODE: mode[3:0] must be exactly one-hot, else frame_error, err_code=01, return to IDLE. Otherwise latch the byte and go to ADDR.
- ADDR: latch the address, then:
  - rd1/rd2 -> ISSUE (or CHK).
  - wr1 -> D_LO.
  - wr2 -> D_HI.
- D_HI: byte goes to data[15:8]. D_LO: byte goes to data[7:0].
- wr1: data[15:8]=0. Reads: data=0. Data register is cleared on entry to MODE.
- ISSUE: instr_valid=1 starting the cycle after the last byte. instr_* stay stable while valid.
  - valid&&i2c_ready -> IDLE next cycle; instr_valid deasserts the same edge.
  - Minimum latency from last byte to instr_valid: 1 cycle.
- rx_valid during ISSUE: byte dropped, frame_error, err_code=11. The pending instruction remains valid and unaffected.
- A HEADER_BYTE value inside MODE..D_LO is treated as data, not a resync.
- Timeout counter:
  - Reset on every accepted byte and on entering MODE.
  - Counts in MODE..CHK; saturating, width $clog2(TIMEOUT_CYCLES+1).
  - On reaching TIMEOUT_CYCLES: frame_error, err_code=10, return to IDLE.
  - rx_valid arriving in the same cycle the count hits the limit wins: the byte is accepted and there is no timeout.
  - Counter does not run in ISSUE, so an I2C stall never times out.
- busy = (state != IDLE).

Optional Feature:
UART_FRAME_CHECKSUM_EN:
- Defined: a CHK byte follows the last payload byte. It must equal the XOR of mode, address and all data bytes.
  - Mismatch: drop, frame_error, err_code=11.
  - Match: go to ISSUE.
  - Timeout also applies in CHK.
- Undefined: CHK state, XOR accumulator and comparator are absent; the last payload byte goes straight to ISSUE.

Decomposition:
- Shared package i2c_pkg:
  - FSM state enum.
  - Mode one-hot localparams (MODE_RD1/RD2/WR1/WR2).
  - err_code localparams.
  - HEADER_BYTE default.
  - Function payload_len(mode) -> 0/1/2.
- The arbiter's mode decode also uses these.
- One sub-module, rx_frame_timer: the saturating timeout counter with clear/enable/expired ports.

Test Plan:
- A5,01,48, i2c_ready=1 -> 1 cycle after last byte: instr_valid=1, mode=01, addr=48, data=0000; deasserts after the handshake; no frame_error.
- A5,08,20,12,34, i2c_ready held 0 for 10 cycles -> instr_valid held stable, data=1234, busy=1; i2c_ready=1 -> accepted, IDLE next cycle.
- A5,04,03,7F -> data=007F. Then A5,03 -> frame_error pulse, err_code=01, no instr_valid.
- A5,02 then silence for TIMEOUT_CYCLES -> frame_error, err_code=10, IDLE. Byte exactly at the limit -> accepted, no error.
- Pending ISSUE plus extra byte 55 -> frame_error, err_code=11, original instruction still issued intact. Then reset=0 mid-frame -> all outputs 0, no pulse.
- With UART_FRAME_CHECKSUM_EN: A5,01,48,49 -> issued; A5,01,48,00 -> frame_error, err_code=11.
